sprite_mover: RTL and testbench

- Parametrised successor of the single-sprite movement controller. Moves one maze sprite (player or ghost) on a tick-divided grid.
- Supports buffered turn requests with expiry and a horizontal tunnel wrap-around window.
- Collision flags come from four external collision detectors that evaluate the current position. This block only decides direction and updates position.
- Sits between button/AI direction source and the renderer/collision logic.

---
 rtl/pacman_pkg.sv | 20 ++
 rtl/move_tick_gen.sv | 30 +++
 rtl/sprite_mover.sv | 119 +++++++++++
 tb/tb_sprite_mover.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// rtl/pacman_pkg.sv - shared direction encodings, defaults and helpers for maze sprites
// Contents: DIR_* one-hot headings in {L,U,R,D} bit order, default start position,
// is_onehot4() request validity check.
package pacman_pkg;

  localparam logic [3:0] DIR_L    = 4'b1000;
  localparam logic [3:0] DIR_U    = 4'b0100;
  localparam logic [3:0] DIR_R    = 4'b0010;
  localparam logic [3:0] DIR_D    = 4'b0001;
  localparam logic [3:0] DIR_NONE = 4'b0000;

  // Default spawn point, shared by the player and ghost instances.
  localparam int START_X_DEF = 200;
  localparam int START_Y_DEF = 230;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/move_tick_gen.sv
// rtl/move_tick_gen.sv - divides the clock into move ticks
// Ports: clk, rst (sync, active-high), en (freezes the counter when low),
//        tick (high in the last cycle of each TICK_DIV-cycle period while en=1).
module move_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] tick_cnt;

  assign tick = en && (tick_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else if (en) begin
      tick_cnt <= tick_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sprite_mover.sv
// rtl/sprite_mover.sv - single maze sprite heading/position controller
// Ports: clk, rst (sync, active-high), en (movement enable), btn (one-hot {L,U,R,D}
//        request), collide (blocked flags for current position), p_x/p_y (position),
//        dir (heading, 0 = idle), moving (last tick moved), turned (heading-change pulse).
module sprite_mover
  import pacman_pkg::*;
#(
  parameter int COORD_W   = 9,
  parameter int START_X   = START_X_DEF,
  parameter int START_Y   = START_Y_DEF,
  parameter int STEP      = 1,
  parameter int TICK_DIV  = 4,
  parameter int TURN_HOLD = 16,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 447
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [3:0]         btn,
  input  logic [3:0]         collide,
  output logic [COORD_W-1:0] p_x,
  output logic [COORD_W-1:0] p_y,
  output logic [3:0]         dir,
  output logic               moving,
  output logic               turned
);

  localparam int W1 = COORD_W + 1;
  localparam int HW = $clog2(TURN_HOLD + 1);
  localparam logic [W1-1:0] STEP_W   = W1'(STEP);
  localparam logic [W1-1:0] SPAN     = W1'(X_MAX - X_MIN + 1);
  localparam logic [W1-1:0] XLO_STEP = W1'(X_MIN + STEP);
  localparam logic [W1-1:0] XHI      = W1'(X_MAX);
  localparam logic [HW-1:0] HOLD_INIT = HW'(TURN_HOLD);

  logic          tick;
  logic [3:0]    pending;
  logic [HW-1:0] hold_cnt;

  logic          valid;
  logic [3:0]    req;
  logic [HW-1:0] base_hold;
  logic          accept;
  logic [3:0]    hd;
  logic          go;
  logic [W1-1:0] xw, yw, nx, ny;

  move_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  always_comb begin
    valid = is_onehot4(btn);
    // A button pressed on the tick cycle itself beats the buffered request.
    req       = valid ? btn : pending;
    base_hold = valid ? HOLD_INIT : hold_cnt;
    accept    = (req != DIR_NONE) && ((req & collide) == 4'b0000);
    hd        = accept ? req : dir;
    go        = (hd != DIR_NONE) && ((hd & collide) == 4'b0000);
    xw = {1'b0, p_x};
    yw = {1'b0, p_y};
    nx = xw;
    ny = yw;
    // One extra bit of headroom so the left-edge test and wrap never underflow.
    case (hd)
      DIR_L:   nx = (xw < XLO_STEP) ? (xw + SPAN - STEP_W) : (xw - STEP_W);
      DIR_R:   nx = ((xw + STEP_W) > XHI) ? (xw - SPAN + STEP_W) : (xw + STEP_W);
      DIR_U:   ny = yw - STEP_W;
      DIR_D:   ny = yw + STEP_W;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_x      <= COORD_W'(START_X);
      p_y      <= COORD_W'(START_Y);
      dir      <= DIR_NONE;
      moving   <= 1'b0;
      turned   <= 1'b0;
      pending  <= DIR_NONE;
      hold_cnt <= '0;
    end else begin
      turned <= 1'b0;
      if (valid) begin
        pending  <= btn;
        hold_cnt <= HOLD_INIT;
      end
      if (tick) begin
        if (accept) begin
          dir      <= req;
          pending  <= DIR_NONE;
          hold_cnt <= '0;
          turned   <= (req != dir);
        end else if (req != DIR_NONE) begin
          // Blocked request: this tick uses up one unit of its lifetime.
          if (base_hold <= HW'(1)) begin
            pending  <= DIR_NONE;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= base_hold - HW'(1);
          end
        end
        if (go) begin
          p_x    <= nx[COORD_W-1:0];
          p_y    <= ny[COORD_W-1:0];
          moving <= 1'b1;
        end else begin
          moving <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sprite_mover.sv
// tb/tb_sprite_mover.sv - bench for sprite_mover (default instance and a fast wrap instance)
module tb_sprite_mover;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_a = 1'b1, en_b = 1'b1;
  logic [3:0] btn_a = '0, btn_b = '0, col_a = '0, col_b = '0;
  logic [8:0] x_a, y_a, x_b, y_b;
  logic [3:0] dir_a, dir_b;
  logic       mv_a, mv_b, tn_a, tn_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sprite_mover dut_a (
    .clk(clk), .rst(rst), .en(en_a), .btn(btn_a), .collide(col_a),
    .p_x(x_a), .p_y(y_a), .dir(dir_a), .moving(mv_a), .turned(tn_a)
  );

  sprite_mover #(
    .START_X(1), .STEP(2), .TICK_DIV(1), .TURN_HOLD(2)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .btn(btn_b), .collide(col_b),
    .p_x(x_b), .p_y(y_b), .dir(dir_b), .moving(mv_b), .turned(tn_b)
  );

  typedef struct {
    logic       en;
    logic [3:0] btn;
    logic [3:0] col;
    logic [8:0] x;
    logic [8:0] y;
    logic [3:0] dir;
    logic       mv;
    logic       tn;
  } vec_t;

  vec_t vt[15];

  function automatic logic [31:0] pk(input logic [8:0] x, input logic [8:0] y,
                                     input logic [3:0] d, input logic m, input logic t);
    return {8'h00, x, y, d, m, t};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got x=%0d y=%0d dir=%b mv=%b tn=%b want x=%0d y=%0d dir=%b mv=%b tn=%b",
               nm, got[23:15], got[14:6], got[5:2], got[1], got[0],
               want[23:15], want[14:6], want[5:2], want[1], want[0]);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] st_a();
    return pk(x_a, y_a, dir_a, mv_a, tn_a);
  endfunction

  initial begin
    //          en    btn      col      x       y        dir      mv    tn
    vt[0]  = '{1'b1, 4'b0000, 4'b0000, 9'd1,   9'd230, 4'b0000, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 4'b1000, 4'b0000, 9'd447, 9'd230, 4'b1000, 1'b1, 1'b1};
    vt[2]  = '{1'b1, 4'b0000, 4'b0000, 9'd445, 9'd230, 4'b1000, 1'b1, 1'b0};
    vt[3]  = '{1'b1, 4'b0010, 4'b0000, 9'd447, 9'd230, 4'b0010, 1'b1, 1'b1};
    vt[4]  = '{1'b1, 4'b0000, 4'b0000, 9'd1,   9'd230, 4'b0010, 1'b1, 1'b0};
    vt[5]  = '{1'b1, 4'b0011, 4'b0000, 9'd3,   9'd230, 4'b0010, 1'b1, 1'b0};
    vt[6]  = '{1'b0, 4'b0100, 4'b0000, 9'd3,   9'd230, 4'b0010, 1'b1, 1'b0};
    vt[7]  = '{1'b1, 4'b0000, 4'b0100, 9'd5,   9'd230, 4'b0010, 1'b1, 1'b0};
    vt[8]  = '{1'b1, 4'b0000, 4'b0110, 9'd5,   9'd230, 4'b0010, 1'b0, 1'b0};
    vt[9]  = '{1'b1, 4'b0000, 4'b0000, 9'd7,   9'd230, 4'b0010, 1'b1, 1'b0};
    vt[10] = '{1'b1, 4'b0001, 4'b0001, 9'd9,   9'd230, 4'b0010, 1'b1, 1'b0};
    vt[11] = '{1'b1, 4'b0000, 4'b0000, 9'd9,   9'd232, 4'b0001, 1'b1, 1'b1};
    vt[12] = '{1'b1, 4'b0100, 4'b0000, 9'd9,   9'd230, 4'b0100, 1'b1, 1'b1};
    vt[13] = '{1'b1, 4'b0000, 4'b0100, 9'd9,   9'd230, 4'b0100, 1'b0, 1'b0};
    vt[14] = '{1'b1, 4'b0000, 4'b0000, 9'd9,   9'd228, 4'b0100, 1'b1, 1'b0};

    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    chk("reset_a", st_a(), pk(9'd200, 9'd230, 4'b0000, 1'b0, 1'b0));
    chk("reset_b", pk(x_b, y_b, dir_b, mv_b, tn_b), pk(9'd1, 9'd230, 4'b0000, 1'b0, 1'b0));

    en_a = 1'b0;
    for (int i = 0; i < 15; i++) begin
      en_b  = vt[i].en;
      btn_b = vt[i].btn;
      col_b = vt[i].col;
      cyc(1);
      chk($sformatf("vec_%0d", i), pk(x_b, y_b, dir_b, mv_b, tn_b),
          pk(vt[i].x, vt[i].y, vt[i].dir, vt[i].mv, vt[i].tn));
    end
    btn_b = '0;

    // Default instance: ticks land on every 4th edge after reset release.
    en_a = 1'b1;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(10);
    chk("idle_10", st_a(), pk(9'd200, 9'd230, 4'b0000, 1'b0, 1'b0));
    btn_a = 4'b0010;
    cyc(1);
    btn_a = 4'b0000;
    cyc(1);
    chk("first_tick_r", st_a(), pk(9'd201, 9'd230, 4'b0010, 1'b1, 1'b1));
    cyc(1);
    chk("between_ticks", st_a(), pk(9'd201, 9'd230, 4'b0010, 1'b1, 1'b0));
    cyc(7);
    chk("move_203", st_a(), pk(9'd203, 9'd230, 4'b0010, 1'b1, 1'b0));

    col_a = 4'b0100;
    btn_a = 4'b0100;
    cyc(1);
    btn_a = 4'b0000;
    cyc(3);
    chk("buffered_keep_r", st_a(), pk(9'd204, 9'd230, 4'b0010, 1'b1, 1'b0));
    cyc(8);
    col_a = 4'b0000;
    cyc(4);
    chk("buffered_turn_u", st_a(), pk(9'd206, 9'd229, 4'b0100, 1'b1, 1'b1));
    cyc(4);
    chk("up_step", st_a(), pk(9'd206, 9'd228, 4'b0100, 1'b1, 1'b0));

    en_a  = 1'b0;
    btn_a = 4'b0010;
    cyc(1);
    btn_a = 4'b0000;
    cyc(3);
    chk("en_low_freeze", st_a(), pk(9'd206, 9'd228, 4'b0100, 1'b1, 1'b0));
    en_a = 1'b1;
    cyc(3);
    chk("en_cnt_frozen", st_a(), pk(9'd206, 9'd228, 4'b0100, 1'b1, 1'b0));
    cyc(1);
    chk("en_turn_r", st_a(), pk(9'd207, 9'd228, 4'b0010, 1'b1, 1'b1));

    btn_a = 4'b1000;
    cyc(1);
    btn_a = 4'b0000;
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(4);
    chk("reset_drops_pending", st_a(), pk(9'd200, 9'd230, 4'b0000, 1'b0, 1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
